// File: rtl/hack_fetch.sv
// Hack CPU instruction fetch stage: owns the PC, reads instruction ROM over a
// req/ack handshake, and hands fetched words to the decoder with valid/ready.
module hack_fetch #(
    parameter int                ADDR_W   = 15,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_ack,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        VALID,
        FLUSH
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] rom_addr_d;
    logic [ADDR_W-1:0] inst_pc_d;
    logic [DATA_W-1:0] inst_d;
    logic              rom_req_d;
    logic              inst_valid_d;
    logic              rom_xfer;

    assign rom_xfer = rom_req && rom_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A jump always wins; a stalled fetch cannot be retargeted, so it drains in FLUSH.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                next_state = FETCH;
            end
            FETCH: begin
                if (jump_en && !rom_xfer) begin
                    next_state = FLUSH;
                end else if (rom_xfer && !jump_en) begin
                    next_state = VALID;
                end
            end
            VALID: begin
                if (jump_en || inst_ready) begin
                    next_state = FETCH;
                end
            end
            FLUSH: begin
                if (rom_xfer) begin
                    next_state = FETCH;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        pc_d         = pc;
        rom_req_d    = rom_req;
        rom_addr_d   = rom_addr;
        inst_d       = inst;
        inst_pc_d    = inst_pc;
        inst_valid_d = inst_valid;
        case (state)
            IDLE: begin
                rom_req_d = 1'b1;
                if (jump_en) begin
                    pc_d       = jump_addr;
                    rom_addr_d = jump_addr;
                end else begin
                    rom_addr_d = pc;
                end
            end
            FETCH: begin
                if (jump_en) begin
                    pc_d = jump_addr;
                    if (rom_xfer) begin
                        rom_addr_d = jump_addr;
                    end
                end else if (rom_xfer) begin
                    inst_d       = rom_data;
                    inst_pc_d    = rom_addr;
                    inst_valid_d = 1'b1;
                    pc_d         = rom_addr + ADDR_W'(1);
                    rom_req_d    = 1'b0;
                end
            end
            VALID: begin
                if (jump_en) begin
                    inst_valid_d = 1'b0;
                    pc_d         = jump_addr;
                    rom_addr_d   = jump_addr;
                    rom_req_d    = 1'b1;
                end else if (inst_ready) begin
                    inst_valid_d = 1'b0;
                    rom_addr_d   = pc;
                    rom_req_d    = 1'b1;
                end
            end
            FLUSH: begin
                if (jump_en) begin
                    pc_d = jump_addr;
                end
                if (rom_xfer) begin
                    rom_addr_d = jump_en ? jump_addr : pc;
                end
            end
            default: begin
                rom_req_d    = 1'b0;
                inst_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            rom_req    <= 1'b0;
            rom_addr   <= RESET_PC;
            inst       <= '0;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
        end else begin
            pc         <= pc_d;
            rom_req    <= rom_req_d;
            rom_addr   <= rom_addr_d;
            inst       <= inst_d;
            inst_pc    <= inst_pc_d;
            inst_valid <= inst_valid_d;
        end
    end

endmodule

// File: tb/tb_hack_fetch.sv
// Directed bench for hack_fetch with a ROM model whose ack latency is set per step.
module tb_hack_fetch;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rom_req;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_ack;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_addr;

    int rom_wait    = 0;
    int wait_cnt    = 0;
    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hack_fetch #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .RESET_PC(15'h0000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rom_req   (rom_req),
        .rom_addr  (rom_addr),
        .rom_ack   (rom_ack),
        .rom_data  (rom_data),
        .inst      (inst),
        .inst_pc   (inst_pc),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .jump_en   (jump_en),
        .jump_addr (jump_addr)
    );

    // ROM contents: 0x1000+addr everywhere except a recognisable word at 0x0003.
    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        if (a == 15'h0003) return 16'hEC10;
        return 16'h1000 + DATA_W'(a);
    endfunction

    assign rom_data = rom_word(rom_addr);
    assign rom_ack  = rom_req && (wait_cnt >= rom_wait);

    always @(posedge clk) begin
        if (!rom_req || rom_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ready, input logic jump, input logic [ADDR_W-1:0] target);
        inst_ready = ready;
        jump_en    = jump;
        jump_addr  = target;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkFetch(input string tag, input logic [31:0] addr);
        checkOutput({tag, ".rom_req"}, 32'(rom_req), 32'd1);
        checkOutput({tag, ".rom_addr"}, 32'(rom_addr), addr);
        checkOutput({tag, ".inst_valid"}, 32'(inst_valid), 32'd0);
    endtask

    task automatic checkInst(input string tag, input logic [31:0] data, input logic [31:0] pc);
        checkOutput({tag, ".inst_valid"}, 32'(inst_valid), 32'd1);
        checkOutput({tag, ".inst"}, 32'(inst), data);
        checkOutput({tag, ".inst_pc"}, 32'(inst_pc), pc);
        checkOutput({tag, ".rom_req"}, 32'(rom_req), 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 15'h0000);

        $display("[TB] startup");
        repeat (3) tick();
        checkOutput("rst.rom_req", 32'(rom_req), 32'd0);
        checkOutput("rst.rom_addr", 32'(rom_addr), 32'h0000);
        checkOutput("rst.inst", 32'(inst), 32'h0000);
        checkOutput("rst.inst_pc", 32'(inst_pc), 32'h0000);
        checkOutput("rst.inst_valid", 32'(inst_valid), 32'd0);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 15'h0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkFetch("seq.fetch", 32'(i));
            tick();
            checkInst("seq.inst", 32'h1000 + 32'(i), 32'(i));
        end

        $display("[TB] backpressure");
        tick();
        checkFetch("bp.fetch", 32'h0003);
        applyStimulus(1'b0, 1'b0, 15'h0000);
        tick();
        checkInst("bp.first", 32'hEC10, 32'h0003);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkInst("bp.hold", 32'hEC10, 32'h0003);
        end

        $display("[TB] rom wait states");
        rom_wait = 3;
        applyStimulus(1'b1, 1'b0, 15'h0000);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkFetch("ws.fetch", 32'h0004);
            checkOutput("ws.inst_stable", 32'(inst), 32'hEC10);
        end
        tick();
        checkInst("ws.inst", 32'h1004, 32'h0004);

        $display("[TB] jump in VALID");
        rom_wait = 0;
        applyStimulus(1'b1, 1'b1, 15'h0100);
        tick();
        checkFetch("jv.fetch", 32'h0100);
        applyStimulus(1'b1, 1'b0, 15'h0000);
        tick();
        checkInst("jv.inst", 32'h1100, 32'h0100);

        $display("[TB] jump during stalled fetch");
        rom_wait = 2;
        applyStimulus(1'b1, 1'b1, 15'h0005);
        tick();
        checkFetch("js.fetch5", 32'h0005);
        applyStimulus(1'b1, 1'b1, 15'h0200);
        tick();
        checkFetch("js.flush5a", 32'h0005);
        applyStimulus(1'b1, 1'b0, 15'h0000);
        tick();
        checkFetch("js.flush5b", 32'h0005);
        tick();
        checkFetch("js.fetch200", 32'h0200);
        checkOutput("js.no_old_data", 32'(inst), 32'h1100);
        applyStimulus(1'b1, 1'b1, 15'h0250);
        tick();
        checkFetch("js.flush200a", 32'h0200);
        applyStimulus(1'b1, 1'b1, 15'h0300);
        tick();
        checkFetch("js.flush200b", 32'h0200);
        applyStimulus(1'b1, 1'b0, 15'h0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkFetch("js.fetch300", 32'h0300);
            checkOutput("js.inst_stable", 32'(inst), 32'h1100);
        end
        tick();
        checkInst("js.inst", 32'h1300, 32'h0300);

        $display("[TB] pc wrap");
        rom_wait = 0;
        applyStimulus(1'b1, 1'b1, 15'h7FFF);
        tick();
        checkFetch("wr.fetch7fff", 32'h7FFF);
        applyStimulus(1'b1, 1'b0, 15'h0000);
        tick();
        checkInst("wr.inst7fff", 32'h8FFF, 32'h7FFF);
        tick();
        checkFetch("wr.fetch0", 32'h0000);
        tick();
        checkInst("wr.inst0", 32'h1000, 32'h0000);

        $display("[TB] jump with same-cycle ack");
        tick();
        checkFetch("ja.fetch1", 32'h0001);
        applyStimulus(1'b1, 1'b1, 15'h0040);
        tick();
        checkFetch("ja.fetch40", 32'h0040);
        checkOutput("ja.discard", 32'(inst), 32'h1000);
        applyStimulus(1'b1, 1'b0, 15'h0000);
        tick();
        checkInst("ja.inst", 32'h1040, 32'h0040);

        $display("[TB] async reset mid-fetch");
        rom_wait = 3;
        tick();
        checkFetch("ar.fetch41", 32'h0041);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("ar.rom_req", 32'(rom_req), 32'd0);
        checkOutput("ar.inst_valid", 32'(inst_valid), 32'd0);
        checkOutput("ar.rom_addr", 32'(rom_addr), 32'h0000);
        checkOutput("ar.inst", 32'(inst), 32'h0000);
        rom_wait = 0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checkFetch("ar.refetch", 32'h0000);
        tick();
        checkInst("ar.inst", 32'h1000, 32'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
